// File: rtl/mux_ext_reg_if.sv
// Handshake bundle for mux_ext_reg: upstream select/extend request and
// downstream extended word, each with its own valid/ready pair.
interface mux_ext_reg_if #(
    parameter int IN_W   = 32,
    parameter int OUT_W  = 34,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) ();
    logic [NUM_IN*IN_W-1:0] in_data;
    logic [SEL_W-1:0]       in_sel;
    logic                   in_ext;
    logic                   in_valid;
    logic                   in_ready;
    logic [OUT_W-1:0]       out_data;
    logic [SEL_W-1:0]       out_src;
    logic                   out_err;
    logic                   out_valid;
    logic                   out_ready;

    // Seen from the selector block itself
    modport slave (
        input  in_data, in_sel, in_ext, in_valid, out_ready,
        output in_ready, out_data, out_src, out_err, out_valid
    );

    // Seen from the environment driving the block
    modport master (
        output in_data, in_sel, in_ext, in_valid, out_ready,
        input  in_ready, out_data, out_src, out_err, out_valid
    );
endinterface

// File: rtl/mux_ext_reg.sv
// N-way selector with zero/sign extension and a 2-entry skid-buffered,
// fully registered output stage (valid/ready on both sides).
module mux_ext_reg #(
    parameter int IN_W   = 32,
    parameter int OUT_W  = 34,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_ext_reg_if.slave     bus
);
    if (OUT_W < IN_W) begin : g_bad_width
        $error("mux_ext_reg: OUT_W must be >= IN_W");
    end
    if ((NUM_IN < 2) || (NUM_IN > 16)) begin : g_bad_num
        $error("mux_ext_reg: NUM_IN must be in 2..16");
    end
    if ((2 ** SEL_W) < NUM_IN) begin : g_bad_sel
        $error("mux_ext_reg: SEL_W too narrow for NUM_IN");
    end

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // Widen a word; the fill bits are the sign bit only when sign-extending.
    // Writing the low slice over a filled vector also covers OUT_W == IN_W.
    function automatic logic [OUT_W-1:0] extend_word(input logic [IN_W-1:0] w,
                                                     input logic ext);
        logic [OUT_W-1:0] r;
        r = {OUT_W{ext & w[IN_W-1]}};
        r[IN_W-1:0] = w;
        return r;
    endfunction

    state_t             state_r;
    logic [OUT_W-1:0]   main_data_r;
    logic [SEL_W-1:0]   main_src_r;
    logic               main_err_r;
    logic [OUT_W-1:0]   skid_data_r;
    logic [SEL_W-1:0]   skid_src_r;
    logic               skid_err_r;
    logic               in_ready_r;
    logic               out_valid_r;

    logic [IN_W-1:0]    pick_s;
    logic               err_s;
    logic [OUT_W-1:0]   new_data_s;
    logic               accept_s;
    logic               fire_s;

    // Select the addressed input; an unmatched selector yields zero with err set
    always_comb begin
        pick_s = {IN_W{1'b0}};
        err_s  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (bus.in_sel == SEL_W'(k)) begin
                pick_s = bus.in_data[k*IN_W +: IN_W];
                err_s  = 1'b0;
            end else begin
                pick_s = pick_s;
                err_s  = err_s;
            end
        end
        new_data_s = extend_word(pick_s, bus.in_ext);
    end

    assign accept_s = bus.in_valid & in_ready_r;
    assign fire_s   = out_valid_r & bus.out_ready;

    // Occupancy FSM with main/skid storage; ready and valid are registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= EMPTY;
            main_data_r <= {OUT_W{1'b0}};
            main_src_r  <= {SEL_W{1'b0}};
            main_err_r  <= 1'b0;
            skid_data_r <= {OUT_W{1'b0}};
            skid_src_r  <= {SEL_W{1'b0}};
            skid_err_r  <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (accept_s) begin
                        main_data_r <= new_data_s;
                        main_src_r  <= bus.in_sel;
                        main_err_r  <= err_s;
                        state_r     <= ONE;
                        out_valid_r <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept_s && fire_s) begin
                        main_data_r <= new_data_s;
                        main_src_r  <= bus.in_sel;
                        main_err_r  <= err_s;
                    end else if (accept_s) begin
                        skid_data_r <= new_data_s;
                        skid_src_r  <= bus.in_sel;
                        skid_err_r  <= err_s;
                        state_r     <= TWO;
                        in_ready_r  <= 1'b0;
                    end else if (fire_s) begin
                        state_r     <= EMPTY;
                        out_valid_r <= 1'b0;
                    end
                end
                TWO: begin
                    if (fire_s) begin
                        main_data_r <= skid_data_r;
                        main_src_r  <= skid_src_r;
                        main_err_r  <= skid_err_r;
                        state_r     <= ONE;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= EMPTY;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = main_data_r;
    assign bus.out_src   = main_src_r;
    assign bus.out_err   = main_err_r;
endmodule
